// File: rtl/mem_pkg.sv
// Shared types and size helpers for the main-memory controller.
// Line and word-index geometry is derived from the controller's parameters.
package mem_pkg;

   typedef enum logic [1:0] {
      CTRL_NOP      = 2'd0,
      CTRL_RESPONSE = 2'd1,
      CTRL_READ     = 2'd2,
      CTRL_WRITE    = 2'd3
   } ctrl_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_RD_BURST,
      ST_WR_BURST,
      ST_WR_WAIT,
      ST_WR_ACK
   } state_e;

   localparam int unsigned DATA_W = 16;

   function automatic int unsigned line_words(input int unsigned line_size);
      return line_size / 2;
   endfunction

   function automatic int unsigned beat_w(input int unsigned line_size);
      return $clog2(line_size / 2);
   endfunction

   function automatic int unsigned word_idx_w(input int unsigned addr_w,
                                              input int unsigned line_size);
      return addr_w + beat_w(line_size);
   endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port backing store: synchronous write, one-cycle registered read.
// Contents are deliberately not reset.
module mem_array
   import mem_pkg::*;
#(
   parameter int unsigned IDX_W = 17
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [IDX_W-1:0]  addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**IDX_W];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_ctrl.sv
// Main-memory controller: line-granular READ/WRITE from the cache with a fixed
// access latency and 16-bit word bursts. Tristate buffers live in the wrapper.
module mem_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned CACHE_LINE_SIZE = 16,
   parameter int unsigned ADDR_W          = 14,
   parameter int unsigned MEM_LATENCY     = 100
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr2,
   input  logic [15:0]       data2_in,
   output logic [15:0]       data2_out,
   output logic              data2_oe,
   input  logic [1:0]        ctrl2_in,
   output logic [1:0]        ctrl2_out,
   output logic              ctrl2_oe,
   output logic              busy,
   output logic              protocol_err
);

   localparam int unsigned LINE_WORDS = line_words(CACHE_LINE_SIZE);
   localparam int unsigned BEAT_W     = beat_w(CACHE_LINE_SIZE);
   localparam int unsigned IDX_W      = word_idx_w(ADDR_W, CACHE_LINE_SIZE);
   localparam int unsigned LAT_W      = $clog2(MEM_LATENCY + 1);

   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LINE_WORDS - 1);
   localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(MEM_LATENCY - 1);

   state_e              state_q, state_d;
   logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
   logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d, beat_inc;
   logic [ADDR_W-1:0]   line_q, line_d;
   logic                err_q, err_d;

   logic                mem_we, mem_re;
   logic [IDX_W-1:0]    mem_addr;
   logic [15:0]         mem_rdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         lat_cnt_q  <= '0;
         beat_cnt_q <= '0;
         line_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         lat_cnt_q  <= lat_cnt_d;
         beat_cnt_q <= beat_cnt_d;
         line_q     <= line_d;
         err_q      <= err_d;
      end
   end

   // During a read burst beat_cnt already points at the next word, so the
   // registered array read lands exactly on the edge that presents it.
   always_comb begin
      state_d    = state_q;
      lat_cnt_d  = lat_cnt_q;
      beat_cnt_d = beat_cnt_q;
      line_d     = line_q;
      err_d      = err_q;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      mem_addr   = {line_q, beat_cnt_q};
      busy       = 1'b1;
      ctrl2_oe   = 1'b0;
      data2_oe   = 1'b0;
      ctrl2_out  = CTRL_NOP;
      beat_inc   = (beat_cnt_q == BEAT_LAST) ? '0 : beat_cnt_q + BEAT_W'(1);

      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            case (ctrl2_in)
               CTRL_READ: begin
                  line_d     = addr2;
                  beat_cnt_d = '0;
                  lat_cnt_d  = '0;
                  state_d    = ST_RD_WAIT;
               end
               CTRL_WRITE: begin
                  line_d     = addr2;
                  mem_we     = 1'b1;
                  mem_addr   = {addr2, BEAT_W'(0)};
                  beat_cnt_d = BEAT_W'(1);
                  state_d    = ST_WR_BURST;
               end
               CTRL_RESPONSE: err_d = 1'b1;
               default: ;
            endcase
         end
         ST_RD_WAIT: begin
            if (lat_cnt_q == LAT_LAST) begin
               mem_re     = 1'b1;
               beat_cnt_d = beat_inc;
               state_d    = ST_RD_BURST;
            end else begin
               lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
         end
         ST_RD_BURST: begin
            ctrl2_oe  = 1'b1;
            data2_oe  = 1'b1;
            ctrl2_out = CTRL_RESPONSE;
            if (beat_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               mem_re     = 1'b1;
               beat_cnt_d = beat_inc;
            end
         end
         ST_WR_BURST: begin
            mem_we     = 1'b1;
            beat_cnt_d = beat_inc;
            if (beat_cnt_q == BEAT_LAST) begin
               lat_cnt_d = '0;
               state_d   = ST_WR_WAIT;
            end
         end
         ST_WR_WAIT: begin
            if (lat_cnt_q == LAT_LAST) begin
               state_d = ST_WR_ACK;
            end else begin
               lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
         end
         ST_WR_ACK: begin
            ctrl2_oe  = 1'b1;
            ctrl2_out = CTRL_RESPONSE;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_q != ST_IDLE && ctrl2_in != CTRL_NOP) begin
         err_d = 1'b1;
      end
   end

   mem_array #(
      .IDX_W(IDX_W)
   ) u_array (
      .clk     (clk),
      .we_i    (mem_we && reset),
      .re_i    (mem_re),
      .addr_i  (mem_addr),
      .wdata_i (data2_in),
      .rdata_o (mem_rdata)
   );

   assign data2_out    = data2_oe ? mem_rdata : '0;
   assign protocol_err = err_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed, table-driven bench for mem_ctrl with MEM_LATENCY=4 and 8-word lines.
module tb_mem_ctrl;

   localparam int unsigned LAT = 4;
   localparam int unsigned W   = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [13:0] addr2;
   logic [15:0] data2_in;
   logic [15:0] data2_out;
   logic        data2_oe;
   logic [1:0]  ctrl2_in;
   logic [1:0]  ctrl2_out;
   logic        ctrl2_oe;
   logic        busy;
   logic        protocol_err;

   int checks = 0;
   int errors = 0;

   mem_ctrl #(
      .CACHE_LINE_SIZE(16),
      .ADDR_W(14),
      .MEM_LATENCY(LAT)
   ) dut (
      .clk          (clk),
      .reset        (rst_n),
      .addr2        (addr2),
      .data2_in     (data2_in),
      .data2_out    (data2_out),
      .data2_oe     (data2_oe),
      .ctrl2_in     (ctrl2_in),
      .ctrl2_out    (ctrl2_out),
      .ctrl2_oe     (ctrl2_oe),
      .busy         (busy),
      .protocol_err (protocol_err)
   );

   always #5 clk = ~clk;

   // exp_ctl = {busy, ctrl2_oe, data2_oe, ctrl2_out, protocol_err}
   typedef struct {
      logic [1:0]  ctrl;
      logic [13:0] addr;
      logic [15:0] din;
      logic [5:0]  exp_ctl;
      logic        chk_data;
      logic [15:0] exp_data;
   } vec_t;

   vec_t q[$];
   logic exp_err = 1'b0;
   int   row_no  = 0;

   task automatic push(input logic [1:0] c, input logic [13:0] a, input logic [15:0] d,
                       input logic b, input logic coe, input logic doe,
                       input logic chk, input logic [15:0] ed);
      vec_t v;
      v.ctrl     = c;
      v.addr     = a;
      v.din      = d;
      v.exp_ctl  = {b, coe, doe, (coe ? 2'b01 : 2'b00), exp_err};
      v.chk_data = chk;
      v.exp_data = ed;
      q.push_back(v);
   endtask

   task automatic chk_ctl(input string nm, input logic [5:0] exp);
      logic [5:0] got;
      got = {busy, ctrl2_oe, data2_oe, ctrl2_out, protocol_err};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s row %0d: {busy,ctrl_oe,data_oe,ctrl_out,err} got %b expected %b",
                  nm, row_no, got, exp);
      end
   endtask

   task automatic chk_data(input string nm, input logic [15:0] exp);
      checks++;
      if (data2_out !== exp) begin
         errors++;
         $display("FAIL %s row %0d: data2_out got %h expected %h", nm, row_no, data2_out, exp);
      end
   endtask

   task automatic run_rows(input string nm);
      for (int i = 0; i < q.size(); i++) begin
         ctrl2_in = q[i].ctrl;
         addr2    = q[i].addr;
         data2_in = q[i].din;
         @(posedge clk);
         #1;
         chk_ctl(nm, q[i].exp_ctl);
         if (q[i].chk_data) chk_data(nm, q[i].exp_data);
         row_no++;
      end
      q.delete();
      ctrl2_in = 2'd0;
   endtask

   task automatic add_idle(input int n);
      for (int i = 0; i < n; i++) push(2'd0, 14'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
   endtask

   // Write a full line: word k = base+k. Ack pulse on the row W-1+LAT after the command.
   task automatic add_write(input logic [13:0] a, input logic [15:0] base);
      push(2'd3, a, base, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      for (int k = 1; k < int'(W); k++)
         push(2'd0, 14'h0, base + 16'(k), 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      for (int k = 0; k < int'(LAT) - 1; k++)
         push(2'd0, 14'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      push(2'd0, 14'h0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
      push(2'd0, 14'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
   endtask

   // Read a line: word k expected = new_base+k for k<n_new, else old_base+k.
   // With intrude set, a WRITE is issued on the first RD_WAIT cycle.
   task automatic add_read(input logic [13:0] a, input logic [15:0] new_base, input int n_new,
                           input logic [15:0] old_base, input logic intrude);
      push(2'd2, a, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      for (int k = 1; k < int'(LAT); k++) begin
         if (intrude && k == 1) begin
            exp_err = 1'b1;
            push(2'd3, 14'h0000, 16'hDEAD, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
         end else begin
            push(2'd0, 14'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
         end
      end
      for (int k = 0; k < int'(W); k++)
         push(2'd0, 14'h0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b1,
              (k < n_new) ? new_base + 16'(k) : old_base + 16'(k));
      push(2'd0, 14'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
   endtask

   initial begin
      rst_n    = 1'b0;
      ctrl2_in = 2'd0;
      addr2    = '0;
      data2_in = '0;

      repeat (3) @(posedge clk);
      #1;
      chk_ctl("in_reset", 6'b0);
      chk_data("in_reset", 16'h0);
      #3 rst_n = 1'b1;

      for (int i = 0; i < 20; i++) push(2'd0, 14'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      run_rows("reset_idle");

      add_write(14'h0123, 16'h1000);
      add_read(14'h0123, 16'h1000, 8, 16'h0, 1'b0);
      add_write(14'h0000, 16'h2000);
      add_write(14'h3FFF, 16'h3000);
      add_read(14'h0000, 16'h2000, 8, 16'h0, 1'b0);
      add_read(14'h3FFF, 16'h3000, 8, 16'h0, 1'b0);
      add_read(14'h0123, 16'h1000, 8, 16'h0, 1'b0);
      run_rows("write_read");

      add_read(14'h0123, 16'h1000, 8, 16'h0, 1'b1);
      add_read(14'h0000, 16'h2000, 8, 16'h0, 1'b0);
      add_idle(3);
      run_rows("busy_cmd");

      // Reset lands between beat 2 and beat 3 of a write.
      push(2'd3, 14'h0123, 16'h4000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      push(2'd0, 14'h0, 16'h4001, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      push(2'd0, 14'h0, 16'h4002, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      run_rows("mid_write");
      data2_in = 16'h4003;
      #2 rst_n = 1'b0;
      #1;
      chk_ctl("mid_reset", 6'b0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      exp_err = 1'b0;
      add_idle(1);
      add_read(14'h0123, 16'h4000, 3, 16'h1000, 1'b0);
      run_rows("after_reset");

      exp_err = 1'b1;
      push(2'd1, 14'h0123, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      add_idle(2);
      add_read(14'h3FFF, 16'h3000, 8, 16'h0, 1'b0);
      add_idle(2);
      run_rows("illegal_cmd");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach end, required completion");
      $fatal(1, "timeout");
   end

endmodule
